// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster generator: DrawX/DrawY, registered hs/vs/display_en, line/frame strobes.
// Build option: define VGA_PIX_DIV_EN to tick every other Clk (50 MHz Clk -> 25 MHz pixels).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_TOTAL  = 525
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       display_en,
  output logic       pixel_tick,
  output logic       line_end,
  output logic       frame_start
);
  localparam logic [9:0] HMAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VMAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HACT   = 10'(H_ACTIVE);
  localparam logic [9:0] VACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       tick_q;
  logic [9:0] hc_nxt, vc_nxt;

  // Tick is registered so the cycle right after any reset shows no pulses.
  always_ff @(posedge Clk) begin
    if (Reset) tick_q <= 1'b0;
`ifdef VGA_PIX_DIV_EN
    else       tick_q <= ~tick_q;
`else
    else       tick_q <= 1'b1;
`endif
  end

  always_comb begin
    hc_nxt = DrawX + 10'd1;
    vc_nxt = DrawY;
    if (DrawX == HMAX) begin
      hc_nxt = '0;
      vc_nxt = (DrawY == VMAX) ? '0 : DrawY + 10'd1;
    end
  end

  // Sync/enable come from the next counter values so they land with DrawX/DrawY.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DrawX      <= '0;
      DrawY      <= '0;
      hs         <= 1'b1;
      vs         <= 1'b1;
      display_en <= 1'b0;
    end else if (tick_q) begin
      DrawX      <= hc_nxt;
      DrawY      <= vc_nxt;
      hs         <= ~((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
      vs         <= ~((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
      display_en <= (hc_nxt < HACT) && (vc_nxt < VACT);
    end
  end

  assign pixel_tick  = tick_q;
  assign line_end    = tick_q && (DrawX == HMAX);
  assign frame_start = tick_q && (DrawX == '0) && (DrawY == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset/line/mid-line reset, shrunken instance for frame wrap.
module tb_vga_timing_gen;
`ifdef VGA_PIX_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_s;
  logic [9:0] dx, dy, dx_s, dy_s;
  logic       hs, vs, de, pt, le, fs;
  logic       hs_s, vs_s, de_s, pt_s, le_s, fs_s;
  logic [25:0] obs, obs_s;
  assign obs   = {dx, dy, hs, vs, de, pt, le, fs};
  assign obs_s = {dx_s, dy_s, hs_s, vs_s, de_s, pt_s, le_s, fs_s};

  vga_timing_gen u_dut (
    .Clk(clk), .Reset(rst), .DrawX(dx), .DrawY(dy), .hs(hs), .vs(vs),
    .display_en(de), .pixel_tick(pt), .line_end(le), .frame_start(fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_TOTAL(16),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_TOTAL(9)
  ) u_small (
    .Clk(clk), .Reset(rst_s), .DrawX(dx_s), .DrawY(dy_s), .hs(hs_s), .vs(vs_s),
    .display_en(de_s), .pixel_tick(pt_s), .line_end(le_s), .frame_start(fs_s)
  );

  int checks = 0;
  int failures = 0;
  logic [25:0] rst_vec, first_vec;

  // Expected outputs s samples after the first post-reset edge (s=0 is the first tick).
  function automatic logic [25:0] exp_out(int s, int ha, int hfp, int hsy, int ht,
                                          int va, int vfp, int vsy, int vt);
    int  pos = (s + DIV - 1) / DIV;
    int  h   = pos % ht;
    int  v   = (pos / ht) % vt;
    bit  t   = (s % DIV) == 0;
    return {10'(h), 10'(v),
            !((h >= ha + hfp) && (h < ha + hfp + hsy)),
            !((v >= va + vfp) && (v < va + vfp + vsy)),
            (s != 0) && (h < ha) && (v < va),
            t, t && (h == ht - 1), t && (h == 0) && (v == 0)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (obs !== rst_vec) begin
        failures++;
        $display("FAIL reset_state got=%h exp=%h", obs, rst_vec);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== first_vec) begin
      failures++;
      $display("FAIL first_tick got=%h exp=%h", obs, first_vec);
    end
  endtask

  task automatic test_line();
    int hs_cnt = 0, hs_first = -1, le_cnt = 0, le_x = -1, y1_x = -1;
    logic [25:0] e;
    for (int s = 1; s <= 1610 * DIV; s++) begin
      @(negedge clk);
      e = exp_out(s, 640, 16, 96, 800, 480, 10, 2, 525);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL line_trace s=%0d got=%h exp=%h", s, obs, e);
      end
      if (dy == 10'd0 && pt && !hs) begin
        if (hs_cnt == 0) hs_first = int'(dx);
        hs_cnt++;
      end
      if (dy == 10'd0 && le) begin le_cnt++; le_x = int'(dx); end
      if (dy == 10'd1 && y1_x < 0) y1_x = int'(dx);
    end
    checks++;
    if (hs_cnt != 96) begin failures++; $display("FAIL hs_low_ticks got=%0d exp=96", hs_cnt); end
    checks++;
    if (hs_first != 656) begin failures++; $display("FAIL hs_low_start got=%0d exp=656", hs_first); end
    checks++;
    if (le_cnt != 1) begin failures++; $display("FAIL line_end_count got=%0d exp=1", le_cnt); end
    checks++;
    if (le_x != 799) begin failures++; $display("FAIL line_end_x got=%0d exp=799", le_x); end
    checks++;
    if (y1_x != 0) begin failures++; $display("FAIL drawy_inc_x got=%0d exp=0", y1_x); end
  endtask

  task automatic test_mid_reset();
    int budget = 2000 * DIV;
    logic [25:0] e;
    while (!(dx == 10'd300 && pt) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL reach_x300 got=%0d exp=300", dx);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== rst_vec) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=%h", obs, rst_vec);
    end
    rst = 1'b0;
    for (int s = 0; s <= 900 * DIV; s++) begin
      @(negedge clk);
      e = exp_out(s, 640, 16, 96, 800, 480, 10, 2, 525);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL restart_trace s=%0d got=%h exp=%h", s, obs, e);
      end
    end
  endtask

  task automatic test_frame();
    int fs_cnt = 0, fs_last = -1, fs_gap_bad = 0, vs_cnt = 0, de_cnt = 0;
    int max_x = 0, max_y = 0, corners = 0;
    bit corner = 1'b0;
    logic [25:0] e;
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_s !== rst_vec) begin
      failures++;
      $display("FAIL small_reset got=%h exp=%h", obs_s, rst_vec);
    end
    rst_s = 1'b0;
    for (int s = 0; s < 300 * DIV; s++) begin
      @(negedge clk);
      e = exp_out(s, 8, 2, 3, 16, 4, 1, 2, 9);
      checks++;
      if (obs_s !== e) begin
        failures++;
        $display("FAIL frame_trace s=%0d got=%h exp=%h", s, obs_s, e);
      end
      if (corner) begin
        corner = 1'b0;
        corners++;
        checks++;
        if ({dx_s, dy_s, vs_s} !== {10'd0, 10'd0, 1'b1}) begin
          failures++;
          $display("FAIL wrap_corner got=%0d,%0d vs=%b exp=0,0 vs=1", dx_s, dy_s, vs_s);
        end
      end
      if (pt_s && dx_s == 10'd15 && dy_s == 10'd8) corner = 1'b1;
      if (int'(dx_s) > max_x) max_x = int'(dx_s);
      if (int'(dy_s) > max_y) max_y = int'(dy_s);
      if (fs_s) begin
        if (fs_last >= 0 && s - fs_last != 144 * DIV) fs_gap_bad++;
        fs_last = s;
        fs_cnt++;
      end
      if (s >= 144 * DIV && s < 288 * DIV) begin
        if (pt_s && !vs_s) vs_cnt++;
        if (pt_s && de_s) de_cnt++;
      end
    end
    checks++;
    if (fs_cnt != 3) begin failures++; $display("FAIL frame_start_count got=%0d exp=3", fs_cnt); end
    checks++;
    if (fs_gap_bad != 0) begin failures++; $display("FAIL frame_period bad_gaps=%0d exp=0", fs_gap_bad); end
    checks++;
    if (vs_cnt != 32) begin failures++; $display("FAIL vs_low_ticks got=%0d exp=32", vs_cnt); end
    checks++;
    if (de_cnt != 32) begin failures++; $display("FAIL display_en_ticks got=%0d exp=32", de_cnt); end
    checks++;
    if (max_x != 15) begin failures++; $display("FAIL max_drawx got=%0d exp=15", max_x); end
    checks++;
    if (max_y != 8) begin failures++; $display("FAIL max_drawy got=%0d exp=8", max_y); end
    checks++;
    if (corners != 2) begin failures++; $display("FAIL corner_count got=%0d exp=2", corners); end
  endtask

  initial begin
    rst     = 1'b1;
    rst_s   = 1'b1;
    rst_vec   = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    first_vec = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    test_reset();
    test_line();
    test_mid_reset();
    test_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster scan that the color mapper consumes: DrawX/DrawY pixel coordinates plus hs/vs sync and a display-enable qualifier for the 640x480 VGA output.
- It is the producer end of the DrawX/DrawY/RGB pixel interface. The mapper returns RGB combinationally for the coordinate presented on the same cycle.
- Also emits line-end and frame-start pulses. Game logic (pacman/ghost movement, fruit timers) uses them as its per-frame update strobe.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_TOTAL, 800, total pixels per line
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_TOTAL, 525, total lines per frame

Ports:
- Clk  input  1  system clock; all state on rising edge
- Reset  input  1  synchronous, active-high reset
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- hs  output  1  horizontal sync, active-low
- vs  output  1  vertical sync, active-low
- display_en  output  1  high when DrawX<H_ACTIVE and DrawY<V_ACTIVE
- pixel_tick  output  1  high on cycles where the counters advance
- line_end  output  1  one-tick pulse at DrawX==H_TOTAL-1
- frame_start  output  1  one-tick pulse at DrawX==0, DrawY==0

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high. Reset takes priority over any tick.
- Reset values: DrawX=0, DrawY=0, hs=1, vs=1, display_en=0, pixel_tick=0, line_end=0, frame_start=0.
- Counters:
  - Registered hc (DrawX) and vc (DrawY), both 10 bits. They advance only when the internal tick is 1.
  - hc: H_TOTAL-1 wraps to 0; otherwise hc+1.
  - On hc wrap: vc increments. If vc==V_TOTAL-1, vc wraps to 0.
  - Values never exceed H_TOTAL-1 / V_TOTAL-1. No other wrap paths exist.
- Output timing:
  - hs, vs and display_en are registers computed from the next-state counter values, so they align with DrawX/DrawY on the same cycle. Zero relative latency and no combinational glitches.
  - hs=0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs=0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491).
  - display_en=0 in the first cycle after Reset deasserts only if no tick has occurred yet. After that it strictly follows the counters.
- Pulses:
  - line_end = pixel_tick AND hc==H_TOTAL-1.
  - frame_start = pixel_tick AND hc==0 AND vc==0, including the first tick after reset.
  - Both are combinational from registered state; each is high for exactly one tick per line/frame.
- Downstream contract: DrawX/DrawY are stable for the whole tick period. The mapper output is sampled at the DAC with the same cycle's hs/vs. This block adds no pipeline delay on RGB.
- Reset mid-frame (e.g. at 300,200): the next cycle shows DrawX=0, DrawY=0, hs=1, vs=1, all pulses 0. Scan restarts from the origin with no partial sync.
- Frame length: H_TOTAL*V_TOTAL = 420000 ticks.

Optional Feature:
- Macro: VGA_PIX_DIV_EN.
- Defined:
  - An internal toggle flop (reset 0) divides Clk by 2, for a 50 MHz Clk driving a 25 MHz pixel rate.
  - tick = toggle==1, so pixel_tick alternates 0/1 starting 0 after reset.
  - Counters and registered outputs hold on non-tick cycles; a frame is 840000 Clk cycles.
- Undefined:
  - tick=1 on every cycle not in reset; pixel_tick=1 continuously after reset release.
  - The toggle flop does not exist.
- Port list is identical in both builds.

Test Plan:
- Reset held 5 cycles, then released -> during reset DrawX=0, DrawY=0, hs=1, vs=1, display_en=0, pulses 0. The first tick after release gives frame_start=1 at (0,0).
- One full line -> hs low for exactly 96 consecutive ticks beginning when DrawX=656. line_end is high once, at DrawX=799. DrawY increments on the following tick.
- One full frame -> vs low only while DrawY is 490 or 491 (1600 ticks). frame_start occurs exactly once per 420000 ticks. display_en is high on exactly 307200 ticks.
- Wrap corner -> at (799,524) the next tick gives (0,0) with frame_start=1 and vs=1. DrawX never reads 800 and DrawY never reads 525.
- Reset asserted for 1 cycle at DrawX=300, DrawY=200 -> the next cycle shows (0,0), hs=1, vs=1. The counting sequence then repeats the post-reset trace identically.
- VGA_PIX_DIV_EN defined -> pixel_tick pattern 0,1,0,1 after reset. DrawX advances once per 2 Clk cycles, and frame_start repeats every 840000 Clk cycles.
